// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its environment.
// The environment (PLL wrapper side) is the master; the supervisor is the slave.
interface pll_lock_supervisor_if #(
   parameter int CNT_W = 8
);
   logic             lock_raw;
   logic             force_relock;
   logic             pll_rst;
   logic             locked;
   logic             sys_rst;
   logic [CNT_W-1:0] relock_cnt;
   logic             fail;

   modport master (
      output lock_raw, force_relock,
      input  pll_rst, locked, sys_rst, relock_cnt, fail
   );

   modport slave (
      input  lock_raw, force_relock,
      output pll_rst, locked, sys_rst, relock_cnt, fail
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies the synchronised lock and
// holds the downstream system reset until lock has been stable; repeated timeouts end in FAIL.
module pll_lock_supervisor #(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 50000,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int SYS_RST_HOLD_CYC = 64,
   parameter int MAX_RETRY        = 8,
   parameter int CNT_W            = 8
) (
   input logic                  clk,
   input logic                  rst,
   pll_lock_supervisor_if.slave bus
);
   localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
   localparam int MAX_CD  = (LOCK_STABLE_CYC > SYS_RST_HOLD_CYC) ? LOCK_STABLE_CYC : SYS_RST_HOLD_CYC;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int TMR_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;
   localparam int RTRY_W  = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [TMR_W-1:0]  RST_LAST     = TMR_W'(RST_PULSE_CYC - 1);
   localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
   // The lk_s=1 sample that moved WAIT_LOCK into STABLE is the first of the
   // consecutive stable cycles, so STABLE itself only needs LOCK_STABLE_CYC-1 more.
   localparam logic [TMR_W-1:0]  STABLE_LAST  = TMR_W'((LOCK_STABLE_CYC > 1) ? LOCK_STABLE_CYC - 2 : 0);
   localparam logic [TMR_W-1:0]  HOLD_LAST    = TMR_W'(SYS_RST_HOLD_CYC - 1);
   localparam logic [RTRY_W-1:0] RETRY_LAST   = RTRY_W'(MAX_RETRY - 1);

   typedef enum logic [2:0] {
      S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_HOLD, S_RUN, S_FAIL
   } state_t;

   typedef struct packed {
      state_t            state;
      logic [RTRY_W-1:0] retry;
      logic              loss;
   } step_t;

   typedef struct packed {
      logic pll_rst;
      logic sys_rst;
      logic locked;
      logic fail;
   } outs_t;

   state_t            state;
   logic [TMR_W-1:0]  timer;
   logic [RTRY_W-1:0] retry;
   logic [CNT_W-1:0]  relock_cnt;
   logic              lk_m, lk_s;
   step_t             step;
   outs_t             outs;

   function automatic step_t fsm_step(input state_t st, input logic [TMR_W-1:0] tmr,
                                      input logic lk, input logic frc,
                                      input logic [RTRY_W-1:0] rty);
      step_t s;
      s.state = st;
      s.retry = rty;
      s.loss  = 1'b0;
      case (st)
         S_PLL_RST:   if (tmr == RST_LAST) s.state = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (lk) begin
               s.state = S_STABLE;
            end else if (tmr == TIMEOUT_LAST) begin
               s.retry = rty + RTRY_W'(1);
               s.state = (rty == RETRY_LAST) ? S_FAIL : S_PLL_RST;
            end
         end
         S_STABLE: begin
            if (!lk) begin
               s.state = S_WAIT_LOCK;
            end else if (tmr == STABLE_LAST) begin
               s.state = S_HOLD;
               s.retry = '0;
            end
         end
         S_HOLD: begin
            if (!lk) begin
               s.state = S_PLL_RST;
               s.loss  = 1'b1;
            end else if (tmr == HOLD_LAST) begin
               s.state = S_RUN;
            end
         end
         S_RUN: begin
            if (!lk) begin
               s.state = S_PLL_RST;
               s.loss  = 1'b1;
            end
         end
         S_FAIL:  s.state = S_FAIL;
         default: s.state = S_PLL_RST;
      endcase
      // A forced re-acquisition overrides the transition but not the loss count.
      if (frc && (st inside {S_WAIT_LOCK, S_STABLE, S_HOLD, S_RUN})) begin
         s.state = S_PLL_RST;
         s.retry = '0;
      end
      return s;
   endfunction

   function automatic outs_t decode(input state_t st);
      outs_t o;
      o = '{pll_rst: 1'b0, sys_rst: 1'b1, locked: 1'b0, fail: 1'b0};
      case (st)
         S_PLL_RST: o.pll_rst = 1'b1;
         S_HOLD:    o.locked  = 1'b1;
         S_RUN:     begin o.locked = 1'b1; o.sys_rst = 1'b0; end
         S_FAIL:    begin o.pll_rst = 1'b1; o.fail = 1'b1; end
         default:   ;
      endcase
      return o;
   endfunction

   assign step = fsm_step(state, timer, lk_s, bus.force_relock, retry);
   assign outs = decode(step.state);

   // NOTE: state and outputs use <= only; outputs are decoded from the next state so they change on the entry edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         lk_m        <= 1'b0;
         lk_s        <= 1'b0;
         state       <= S_PLL_RST;
         timer       <= '0;
         retry       <= '0;
         relock_cnt  <= '0;
         bus.pll_rst <= 1'b1;
         bus.sys_rst <= 1'b1;
         bus.locked  <= 1'b0;
         bus.fail    <= 1'b0;
      end else begin
         lk_m  <= bus.lock_raw;
         lk_s  <= lk_m;
         state <= step.state;
         retry <= step.retry;
         if (step.state != state) begin
            timer <= '0;
         end else if (timer != '1) begin
            timer <= timer + TMR_W'(1);
         end
         if (step.loss && (relock_cnt != '1)) begin
            relock_cnt <= relock_cnt + CNT_W'(1);
         end
         bus.pll_rst <= outs.pll_rst;
         bus.sys_rst <= outs.sys_rst;
         bus.locked  <= outs.locked;
         bus.fail    <= outs.fail;
      end
   end

   assign bus.relock_cnt = relock_cnt;
endmodule
